// File: rtl/lfsr_operand_gen_if.sv
// lfsr_operand_gen_if
//   Bundles the operand-generator handshake: the enable input and the
//   operand/strobe outputs. It also carries the seed-load pair when the
//   SEED_LOAD_EN macro is defined.
//   master : the consumer/controller side. It drives enable (and seed_load/seed_in).
//   slave  : the lfsr_operand_gen side. It drives value, value_valid and result_valid.
// Signals
//   enable        controller -> gen   advance prescaler while high
//   value         gen -> controller   current LFSR state (comparator operand B)
//   value_valid   gen -> controller   pulse coincident with a new value
//   result_valid  gen -> controller   value_valid delayed one clk
//   seed_load     controller -> gen   [SEED_LOAD_EN] synchronous seed load strobe
//   seed_in       controller -> gen   [SEED_LOAD_EN] seed to load
interface lfsr_operand_gen_if #(
  parameter int WIDTH = 10
);
  logic             enable;
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             result_valid;
`ifdef SEED_LOAD_EN
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
`endif

  modport master (
    input  value, value_valid, result_valid,
`ifdef SEED_LOAD_EN
    output seed_load, seed_in,
`endif
    output enable
  );

  modport slave (
    output value, value_valid, result_valid,
`ifdef SEED_LOAD_EN
    input  seed_load, seed_in,
`endif
    input  enable
  );
endinterface

// File: rtl/lfsr_operand_gen.sv
// lfsr_operand_gen
//   This module is a free-running 10-bit Fibonacci LFSR (x^10+x^7+1). It is the
//   pseudo-random operand source for a registered A>B comparator. A prescaler
//   advances the LFSR once every DIV enabled clocks.
//   value_valid marks each new operand. result_valid is that pulse delayed one
//   clock, so it lines up with the comparator's registered output.
//   Optional feature macro: SEED_LOAD_EN. It adds a synchronous seed load
//   through bus.seed_load/bus.seed_in.
// Ports
//   clk    in  single clock, all state on posedge
//   reset  in  asynchronous, active-high
//   bus    lfsr_operand_gen_if.slave (enable, value, value_valid, result_valid,
//          and seed_load/seed_in when SEED_LOAD_EN is defined)
// Parameters
//   WIDTH  operand width. The taps are fixed for 10 bits.
//   DIV    enabled clk cycles per LFSR step, 1..1023
//   SEED   reset state. A value of 0 is mapped to 1 because the all-zero state would lock up.
module lfsr_operand_gen #(
  parameter int               WIDTH = 10,
  parameter int               DIV   = 4,
  parameter logic [WIDTH-1:0] SEED  = 10'h001
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_operand_gen_if.slave   bus
);

  localparam int               CNT_W    = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             value_valid_q, value_valid_d;
  logic             result_valid_q, result_valid_d;
  logic [WIDTH-1:0] lfsr_next;
  logic             fb;

  // Taps for x^10+x^7+1 on a left-shifting register: bits 9 and 6.
  assign fb        = value_q[WIDTH-1] ^ value_q[WIDTH-4];
  assign lfsr_next = {value_q[WIDTH-2:0], fb};

  always_comb begin
    value_d        = value_q;
    cnt_d          = cnt_q;
    value_valid_d  = 1'b0;
    result_valid_d = value_valid_q;
    if (bus.enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d         = '0;
        value_d       = lfsr_next;
        value_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`ifdef SEED_LOAD_EN
    // A seed load wins over a coincident step, and enable does not gate it.
    // A zero seed is remapped so the all-zero lock-up state is never entered.
    if (bus.seed_load) begin
      value_d       = (bus.seed_in == '0) ? ONE : bus.seed_in;
      cnt_d         = '0;
      value_valid_d = 1'b0;
    end
`endif
  end

  // Async assert. Release takes effect at the first clk edge after reset falls.
  // A partial prescaler count is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q        <= SEED_EFF;
      cnt_q          <= '0;
      value_valid_q  <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      value_q        <= value_d;
      cnt_q          <= cnt_d;
      value_valid_q  <= value_valid_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.value_valid  = value_valid_q;
  assign bus.result_valid = result_valid_q;

endmodule
